// File: rtl/encrypt_ctrl_if.sv
// encrypt_ctrl_if: start/operand, key-memory read and ciphertext stream signals of encrypt_ctrl
interface encrypt_ctrl_if #(
    parameter int PLAINTEXT_WIDTH  = 8,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int BIG_N            = 30,
    parameter int LITTLE_N         = 2,
    parameter int PK_ADDR_WIDTH    = 7
);
    localparam int INDEX_WIDTH = $clog2(LITTLE_N + 1);
    logic                        go;
    logic [PLAINTEXT_WIDTH-1:0]  plaintext;
    logic [BIG_N-1:0]            noise_select;
    logic                        busy;
    logic                        pk_rd_en;
    logic [PK_ADDR_WIDTH-1:0]    pk_addr;
    logic [CIPHERTEXT_WIDTH-1:0] pk_rdata;
    logic                        ct_valid;
    logic                        ct_ready;
    logic [CIPHERTEXT_WIDTH-1:0] ct_data;
    logic [INDEX_WIDTH-1:0]      ct_index;
    logic                        ct_last;
    logic                        done;
    modport master (
        input  go, plaintext, noise_select, pk_rdata, ct_ready,
        output busy, pk_rd_en, pk_addr, ct_valid, ct_data, ct_index, ct_last, done
    );
    modport slave (
        output go, plaintext, noise_select, pk_rdata, ct_ready,
        input  busy, pk_rd_en, pk_addr, ct_valid, ct_data, ct_index, ct_last, done
    );
endinterface

// File: rtl/encrypt_ctrl.sv
// encrypt_ctrl: LWE encryption sequencer; sums noise-selected key samples per column and streams the ciphertext
module encrypt_ctrl #(
    parameter int PLAINTEXT_WIDTH  = 8,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int BIG_N            = 30,
    parameter int LITTLE_N         = 2,
    parameter int PK_ADDR_WIDTH    = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    encrypt_ctrl_if.master bus
);
    localparam int IW = $clog2(LITTLE_N + 1);
    localparam int SW = $clog2(BIG_N);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, EMIT = 2'd3;
    logic [1:0]                  state;
    logic [IW-1:0]               col;
    logic [SW-1:0]               smp;
    logic [CIPHERTEXT_WIDTH-1:0] acc, acc_next, ptx_term;
    logic [PLAINTEXT_WIDTH-1:0]  ptx;
    logic [BIG_N-1:0]            sel;
    logic                        rd_q, sel_q, last_col, last_smp;
    assign bus.busy     = state != IDLE;
    assign bus.pk_rd_en = state == ISSUE;
    assign bus.ct_valid = state == EMIT;
    assign last_col     = col == IW'(LITTLE_N);
    assign last_smp     = smp == SW'(BIG_N - 1);
    // read data lands one cycle after its strobe, so the select bit travels with it in sel_q
    assign acc_next     = acc + (rd_q && sel_q ? bus.pk_rdata : '0);
    assign ptx_term     = last_col ? CIPHERTEXT_WIDTH'(ptx) << (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            smp          <= '0;
            acc          <= '0;
            ptx          <= '0;
            sel          <= '0;
            rd_q         <= 1'b0;
            sel_q        <= 1'b0;
            bus.pk_addr  <= '0;
            bus.ct_data  <= '0;
            bus.ct_index <= '0;
            bus.ct_last  <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            rd_q     <= state == ISSUE;
            sel_q    <= sel[smp];
            bus.done <= state == EMIT && bus.ct_ready && last_col;
            if (rd_q) acc <= acc_next;
            case (state)
                IDLE: if (bus.go && !bus.done) begin
                    ptx         <= bus.plaintext;
                    sel         <= bus.noise_select;
                    col         <= '0;
                    smp         <= '0;
                    acc         <= '0;
                    bus.pk_addr <= '0;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    bus.pk_addr <= bus.pk_addr + PK_ADDR_WIDTH'(1);
                    smp         <= last_smp ? '0 : smp + SW'(1);
                    state       <= last_smp ? DRAIN : ISSUE;
                end
                DRAIN: begin
                    bus.ct_data  <= acc_next + ptx_term;
                    bus.ct_index <= col;
                    bus.ct_last  <= last_col;
                    state        <= EMIT;
                end
                default: if (bus.ct_ready) begin
                    bus.ct_last <= 1'b0;
                    col         <= col + IW'(1);
                    smp         <= '0;
                    acc         <= '0;
                    state       <= last_col ? IDLE : ISSUE;
                end
            endcase
        end
    end
endmodule
